// File: rtl/tpu_pkg.sv
// Shared widths and the accumulator FSM encoding for the product-sum datapath.
package tpu_pkg;

    localparam int IN_W  = 17;
    localparam int ACC_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/mux2_34b.sv
// Two-input word mux; sel = 1 picks b.
module mux2_34b #(
    parameter int W = 34
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/acc_34b.sv
// Framed signed product accumulator: sums first..last beats and holds the
// result until the consumer takes it; sticky framing and term-limit flags.
module acc_34b #(
    parameter int IN_W      = tpu_pkg::IN_W,
    parameter int ACC_W     = tpu_pkg::ACC_W,
    parameter int MAX_TERMS = 1024,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             err_overflow,
    output logic             err_protocol
);

    import tpu_pkg::acc_state_t;
    import tpu_pkg::ST_IDLE;
    import tpu_pkg::ST_ACCUM;
    import tpu_pkg::ST_HOLD;

    localparam int EXT_W = ACC_W - IN_W;

    acc_state_t       state, nxt_state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             accept;
    logic             start;
    logic             append;
    logic             cnt_full;

    assign accept   = in_valid && in_ready;
    // A first beat restarts the sum from either IDLE or ACCUM.
    assign start    = accept && in_first;
    assign append   = accept && !in_first && (state == ST_ACCUM);
    assign cnt_full = (cnt == CNT_W'(MAX_TERMS));

    assign in_ext = {{EXT_W{in_data[IN_W-1]}}, in_data};
    assign sum    = acc + in_ext;

    mux2_34b #(.W(ACC_W)) u_ld_mux (
        .sel (start),
        .a   (sum),
        .b   (in_ext),
        .y   (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (start) nxt_state = in_last ? ST_HOLD : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (accept && in_last) nxt_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != ST_HOLD);
        out_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            if (start || append) acc <= acc_nxt;
            if (start) begin
                cnt <= CNT_W'(1);
            end else if (append) begin
                if (cnt_full) err_overflow <= 1'b1;
                else          cnt <= cnt + CNT_W'(1);
            end
            if (accept && ((state == ST_IDLE && !in_first) || (state == ST_ACCUM && in_first)))
                err_protocol <= 1'b1;
        end
    end

    assign out_data  = acc;
    assign out_count = cnt;

endmodule
